// File: rtl/inst_encoder.sv
// Instruction encoder: builds P6 MIPS words from a mnemonic index plus operand fields and
// queues them in a small FIFO that streams to the IM loader with sequential word addresses.
module inst_encoder #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [4:0]  mnem_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [15:0] imm_i,
  input  logic [25:0] target_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_data_o,
  output logic [31:0] out_addr_o,
  output logic        err_o,
  output logic [7:0]  err_count_o
);

  localparam int unsigned AW     = $clog2(DEPTH);
  localparam logic [AW:0] DepthC = (AW+1)'(DEPTH);

  logic [5:0]  funct, opcode;
  logic        is_r, is_i, enc_legal;
  logic [4:0]  f_rs, f_rt, f_rd;
  logic [31:0] enc_word;

  always_comb begin
    funct     = 6'h00;
    opcode    = 6'h00;
    is_r      = 1'b0;
    is_i      = 1'b0;
    enc_legal = 1'b1;
    f_rs      = rs_i;
    f_rt      = rt_i;
    f_rd      = rd_i;
    case (mnem_i)
      5'd0:  begin is_r = 1'b1; funct = 6'b100000; end
      5'd1:  begin is_r = 1'b1; funct = 6'b100010; end
      5'd2:  begin is_r = 1'b1; funct = 6'b100100; end
      5'd3:  begin is_r = 1'b1; funct = 6'b100101; end
      5'd4:  begin is_r = 1'b1; funct = 6'b101010; end
      5'd5:  begin is_r = 1'b1; funct = 6'b101011; end
      5'd6:  begin is_r = 1'b1; funct = 6'b001000; f_rt = '0; f_rd = '0; end
      5'd7:  begin is_r = 1'b1; funct = 6'b011000; f_rd = '0; end
      5'd8:  begin is_r = 1'b1; funct = 6'b011001; f_rd = '0; end
      5'd9:  begin is_r = 1'b1; funct = 6'b011010; f_rd = '0; end
      5'd10: begin is_r = 1'b1; funct = 6'b011011; f_rd = '0; end
      5'd11: begin is_r = 1'b1; funct = 6'b010000; f_rs = '0; f_rt = '0; end
      5'd12: begin is_r = 1'b1; funct = 6'b010010; f_rs = '0; f_rt = '0; end
      5'd13: begin is_r = 1'b1; funct = 6'b010001; f_rt = '0; f_rd = '0; end
      5'd14: begin is_r = 1'b1; funct = 6'b010011; f_rt = '0; f_rd = '0; end
      5'd15: begin is_i = 1'b1; opcode = 6'b001101; end
      5'd16: begin is_i = 1'b1; opcode = 6'b001000; end
      5'd17: begin is_i = 1'b1; opcode = 6'b001100; end
      5'd18: begin is_i = 1'b1; opcode = 6'b100011; end
      5'd19: begin is_i = 1'b1; opcode = 6'b100001; end
      5'd20: begin is_i = 1'b1; opcode = 6'b100000; end
      5'd21: begin is_i = 1'b1; opcode = 6'b101011; end
      5'd22: begin is_i = 1'b1; opcode = 6'b101001; end
      5'd23: begin is_i = 1'b1; opcode = 6'b101000; end
      5'd24: begin is_i = 1'b1; opcode = 6'b000100; end
      5'd25: begin is_i = 1'b1; opcode = 6'b000101; end
      5'd26: begin is_i = 1'b1; opcode = 6'b001111; f_rs = '0; end
      5'd27, 5'd28: enc_legal = 1'b1;
      default: enc_legal = 1'b0;
    endcase

    if (is_r) begin
      enc_word = {6'b000000, f_rs, f_rt, f_rd, 5'b00000, funct};
    end else if (is_i) begin
      enc_word = {opcode, f_rs, f_rt, imm_i};
    end else if (mnem_i == 5'd27) begin
      enc_word = {6'b000011, target_i};
    end else if (mnem_i == 5'd28) begin
      enc_word = {6'b111111, rs_i, rt_i, rd_i, 5'b00000, 6'b111111};
    end else begin
      enc_word = '0;
    end
  end

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [31:0]   addr_q, addr_d;
  logic          err_q, err_d;
  logic [7:0]    err_cnt_q, err_cnt_d;
  logic          accept, push, pop;

  assign in_ready_o  = count_q < DepthC;
  assign out_valid_o = count_q != '0;
  assign accept      = in_valid_i && in_ready_o;
  // Illegal mnemonics complete the handshake but never occupy a slot.
  assign push        = accept && enc_legal;
  assign pop         = out_valid_o && out_ready_i;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    addr_d    = addr_q;
    count_d   = count_q;
    err_d     = accept && !enc_legal;
    err_cnt_d = err_cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      addr_d   = addr_q + 32'd4;
    end
    if (push && !pop) count_d = count_q + (AW+1)'(1);
    if (pop && !push) count_d = count_q - (AW+1)'(1);
    if (err_d && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      addr_q    <= BASE_ADDR;
      err_q     <= 1'b0;
      err_cnt_q <= 8'd0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      addr_q    <= addr_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !reset_i) mem_q[wr_ptr_q] <= enc_word;
  end

  assign out_data_o  = mem_q[rd_ptr_q];
  assign out_addr_o  = addr_q;
  assign err_o       = err_q;
  assign err_count_o = err_cnt_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Bench for inst_encoder: directed spec vectors plus randomized traffic against a queue model.
module tb_inst_encoder;

  localparam int unsigned DEPTH  = 4;
  localparam logic [31:0] BASE_A = 32'h0000_3000;
  localparam logic [31:0] BASE_B = 32'hFFFF_FFF8;

  localparam logic [5:0] FN [15] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h2B, 6'h08, 6'h18,
                                     6'h19, 6'h1A, 6'h1B, 6'h10, 6'h12, 6'h11, 6'h13};
  localparam logic [5:0] OP [12] = '{6'h0D, 6'h08, 6'h0C, 6'h23, 6'h21, 6'h20, 6'h2B, 6'h29,
                                     6'h28, 6'h04, 6'h05, 6'h0F};

  localparam logic [4:0]  D_M [7] = '{5'd0, 5'd15, 5'd26, 5'd6, 5'd11, 5'd21, 5'd27};
  localparam logic [4:0]  D_S [7] = '{5'd1, 5'd0, 5'd5, 5'd31, 5'd7, 5'd29, 5'd4};
  localparam logic [4:0]  D_T [7] = '{5'd2, 5'd1, 5'd2, 5'd7, 5'd3, 5'd5, 5'd6};
  localparam logic [4:0]  D_D [7] = '{5'd3, 5'd9, 5'd1, 5'd9, 5'd4, 5'd3, 5'd2};
  localparam logic [15:0] D_I [7] = '{16'h0, 16'h1234, 16'hABCD, 16'h0, 16'h0, 16'h8, 16'h0};
  localparam logic [31:0] WANT [7] = '{32'h00221820, 32'h34011234, 32'h3C02ABCD, 32'h03E00008,
                                       32'h00002010, 32'hAFA50008, 32'h0C000C03};

  logic        clk = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic [4:0]  mnem = '0, rs = '0, rt = '0, rd = '0;
  logic [15:0] imm = '0;
  logic [25:0] target = '0;
  logic        in_ready_a, out_valid_a, err_a, in_ready_b, out_valid_b, err_b;
  logic [31:0] out_data_a, out_addr_a, out_data_b, out_addr_b;
  logic [7:0]  err_count_a, err_count_b;

  int          errors = 0, checks = 0;
  logic [31:0] exp_q [$];
  logic [31:0] exp_addr, exp_addr_b;
  logic        exp_err, last_acc;
  logic [7:0]  exp_cnt;

  always #5 clk = ~clk;

  inst_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE_A)) dut (
    .clk_i(clk), .reset_i(reset), .in_valid_i(in_valid), .in_ready_o(in_ready_a),
    .mnem_i(mnem), .rs_i(rs), .rt_i(rt), .rd_i(rd), .imm_i(imm), .target_i(target),
    .out_valid_o(out_valid_a), .out_ready_i(out_ready), .out_data_o(out_data_a),
    .out_addr_o(out_addr_a), .err_o(err_a), .err_count_o(err_count_a)
  );

  inst_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE_B)) dut_b (
    .clk_i(clk), .reset_i(reset), .in_valid_i(in_valid), .in_ready_o(in_ready_b),
    .mnem_i(mnem), .rs_i(rs), .rt_i(rt), .rd_i(rd), .imm_i(imm), .target_i(target),
    .out_valid_o(out_valid_b), .out_ready_i(out_ready), .out_data_o(out_data_b),
    .out_addr_o(out_addr_b), .err_o(err_b), .err_count_o(err_count_b)
  );

  // Returns {legal, word} straight from the instruction-format rules.
  function automatic logic [32:0] ref_enc(input logic [4:0] m, input logic [4:0] s,
                                          input logic [4:0] t, input logic [4:0] d,
                                          input logic [15:0] i, input logic [25:0] tg);
    int mi = int'(m);
    if (mi <= 14) begin
      if (mi inside {6, 13, 14}) begin t = '0; d = '0; end
      if (mi inside {[7:10]}) d = '0;
      if (mi inside {11, 12}) begin s = '0; t = '0; end
      return {1'b1, 6'b0, s, t, d, 5'b0, FN[mi]};
    end
    if (mi <= 26) begin
      if (mi == 26) s = '0;
      return {1'b1, OP[mi-15], s, t, i};
    end
    if (mi == 27) return {1'b1, 6'b000011, tg};
    if (mi == 28) return {1'b1, 6'h3F, s, t, d, 5'b0, 6'h3F};
    return {1'b0, 32'h0};
  endfunction

  task automatic clear_model();
    exp_q.delete();
    exp_addr   = BASE_A;
    exp_addr_b = BASE_B;
    exp_err    = 1'b0;
    exp_cnt    = 8'd0;
  endtask

  // Applies the handshakes the model predicts for the current inputs, then moves to the next
  // sampling point.
  task automatic adv();
    logic [32:0] e;
    logic        acc, pp;
    e   = ref_enc(mnem, rs, rt, rd, imm, target);
    acc = in_valid && (exp_q.size() < DEPTH);
    pp  = out_ready && (exp_q.size() != 0);
    if (pp) begin
      void'(exp_q.pop_front());
      exp_addr   += 32'd4;
      exp_addr_b += 32'd4;
    end
    if (acc && e[32]) exp_q.push_back(e[31:0]);
    exp_err = acc && !e[32];
    if (acc && !e[32] && exp_cnt != 8'hFF) exp_cnt++;
    last_acc = acc;
    @(negedge clk);
  endtask

  task automatic set_req(input logic [4:0] m, input logic [4:0] s, input logic [4:0] t,
                         input logic [4:0] d, input logic [15:0] i, input logic [25:0] tg);
    mnem = m; rs = s; rt = t; rd = d; imm = i; target = tg;
  endtask

  task automatic rand_req(input int lo, input int hi);
    set_req(5'($urandom_range(hi, lo)), 5'($urandom), 5'($urandom), 5'($urandom),
            16'($urandom), 26'($urandom));
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    clear_model();
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks += 6;
    if (out_valid_a !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", out_valid_a); end
    if (in_ready_a !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", in_ready_a); end
    if (out_addr_a !== BASE_A) begin errors++; $display("FAIL rst_addr got %h want %h", out_addr_a, BASE_A); end
    if (err_a !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", err_a); end
    if (err_count_a !== 8'd0) begin errors++; $display("FAIL rst_errcnt got %0d want 0", err_count_a); end
    if (out_addr_b !== BASE_B) begin errors++; $display("FAIL rst_addr_b got %h want %h", out_addr_b, BASE_B); end
  endtask

  task automatic test_directed();
    for (int k = 0; k < 7; k++) begin
      set_req(D_M[k], D_S[k], D_T[k], D_D[k], D_I[k], 26'h0000C03);
      in_valid = 1'b1; out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready_a !== 1'b1) begin errors++; $display("FAIL dir_ready[%0d] got %b want 1", k, in_ready_a); end
      adv();
      in_valid = 1'b0;
      #1;
      checks += 4;
      if (out_valid_a !== 1'b1) begin errors++; $display("FAIL dir_valid[%0d] got %b want 1", k, out_valid_a); end
      if (out_data_a !== WANT[k]) begin errors++; $display("FAIL dir_data[%0d] got %h want %h", k, out_data_a, WANT[k]); end
      if (out_addr_a !== BASE_A + 32'(4 * k)) begin
        errors++; $display("FAIL dir_addr[%0d] got %h want %h", k, out_addr_a, BASE_A + 32'(4 * k));
      end
      if (exp_q.size() == 0 || out_data_a !== exp_q[0]) begin
        errors++; $display("FAIL dir_model[%0d] got %h want model head", k, out_data_a);
      end
      adv();
    end
  endtask

  task automatic test_backpressure();
    logic [4:0]  bm [5], bs [5], bt [5], bd [5];
    logic [15:0] bi [5];
    int          idx = 0, got = 0;
    for (int k = 0; k < 5; k++) begin
      bm[k] = 5'($urandom_range(28, 0)); bs[k] = 5'($urandom); bt[k] = 5'($urandom);
      bd[k] = 5'($urandom); bi[k] = 16'($urandom);
    end
    out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      set_req(bm[idx], bs[idx], bt[idx], bd[idx], bi[idx], 26'h155);
      in_valid = 1'b1;
      #1;
      checks++;
      if (in_ready_a !== (idx < 4)) begin errors++; $display("FAIL bp_ready[%0d] got %b want %b", c, in_ready_a, idx < 4); end
      if (c > 0) begin
        checks++;
        if (out_data_a !== exp_q[0] || out_addr_a !== exp_addr) begin
          errors++; $display("FAIL bp_head[%0d] got %h@%h want %h@%h", c, out_data_a, out_addr_a, exp_q[0], exp_addr);
        end
      end
      adv();
      if (last_acc) idx++;
    end
    out_ready = 1'b1;
    for (int c = 0; c < 20 && (exp_q.size() != 0 || idx < 5); c++) begin
      in_valid = (idx < 5);
      #1;
      checks++;
      if (out_valid_a !== 1'b1 || out_data_a !== exp_q[0] || out_addr_a !== exp_addr) begin
        errors++; $display("FAIL bp_drain[%0d] got %b %h@%h want 1 %h@%h", c, out_valid_a, out_data_a, out_addr_a, exp_q[0], exp_addr);
      end
      got++;
      adv();
      if (last_acc) idx++;
    end
    in_valid = 1'b0;
    #1;
    checks += 2;
    if (got !== 5) begin errors++; $display("FAIL bp_count got %0d want 5", got); end
    if (out_valid_a !== 1'b0) begin errors++; $display("FAIL bp_empty got %b want 0", out_valid_a); end
    adv();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rand_req(0, 31);
      in_valid  = ($urandom_range(3, 0) != 0);
      out_ready = ($urandom_range(2, 0) != 0);
      #1;
      checks += 4;
      if (in_ready_a !== (exp_q.size() < DEPTH)) begin errors++; $display("FAIL rnd_ready[%0d] got %b", c, in_ready_a); end
      if (out_valid_a !== (exp_q.size() != 0)) begin errors++; $display("FAIL rnd_valid[%0d] got %b", c, out_valid_a); end
      if (err_a !== exp_err) begin errors++; $display("FAIL rnd_err[%0d] got %b want %b", c, err_a, exp_err); end
      if (err_count_a !== exp_cnt) begin errors++; $display("FAIL rnd_errcnt[%0d] got %0d want %0d", c, err_count_a, exp_cnt); end
      if (exp_q.size() != 0) begin
        checks++;
        if (out_data_a !== exp_q[0] || out_addr_a !== exp_addr) begin
          errors++; $display("FAIL rnd_head[%0d] got %h@%h want %h@%h", c, out_data_a, out_addr_a, exp_q[0], exp_addr);
        end
      end
      adv();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 6; c++) adv();
  endtask

  task automatic test_illegal();
    int pulses = 0, words = 0;
    do_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      in_valid = (c < 3);
      if (c == 1) set_req(5'd30, 5'd1, 5'd2, 5'd3, 16'h1, 26'h1);
      else rand_req(0, 28);
      #1;
      checks++;
      if (err_a !== exp_err) begin errors++; $display("FAIL ill_err[%0d] got %b want %b", c, err_a, exp_err); end
      if (err_a === 1'b1) pulses++;
      if (out_valid_a === 1'b1) begin
        checks++;
        if (out_data_a !== exp_q[0] || out_addr_a !== BASE_A + 32'(4 * words)) begin
          errors++; $display("FAIL ill_word[%0d] got %h@%h want %h@%h", c, out_data_a, out_addr_a, exp_q[0], BASE_A + 32'(4 * words));
        end
        words++;
      end
      adv();
    end
    checks += 3;
    if (pulses !== 1) begin errors++; $display("FAIL ill_pulses got %0d want 1", pulses); end
    if (words !== 2) begin errors++; $display("FAIL ill_words got %0d want 2", words); end
    if (err_count_a !== 8'd1) begin errors++; $display("FAIL ill_errcnt got %0d want 1", err_count_a); end
    in_valid = 1'b1;
    for (int c = 0; c < 300; c++) begin
      rand_req(29, 31);
      #1;
      checks++;
      if (err_count_a !== exp_cnt) begin errors++; $display("FAIL sat_cnt[%0d] got %0d want %0d", c, err_count_a, exp_cnt); end
      adv();
    end
    in_valid = 1'b0;
    adv();
    #1;
    checks += 3;
    if (err_count_a !== 8'd255) begin errors++; $display("FAIL sat_final got %0d want 255", err_count_a); end
    if (err_a !== 1'b0) begin errors++; $display("FAIL sat_err_clear got %b want 0", err_a); end
    if (out_valid_a !== 1'b0) begin errors++; $display("FAIL sat_nowords got %b want 0", out_valid_a); end
  endtask

  task automatic test_wrap_and_reset();
    logic [31:0] wa [3];
    int          n = 0;
    wa[0] = 32'hFFFF_FFF8; wa[1] = 32'hFFFF_FFFC; wa[2] = 32'h0000_0000;
    do_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      in_valid = (c < 3);
      rand_req(0, 28);
      #1;
      if (out_valid_b === 1'b1 && n < 3) begin
        checks++;
        if (out_addr_b !== wa[n] || out_data_b !== exp_q[0]) begin
          errors++; $display("FAIL wrap[%0d] got %h@%h want %h@%h", n, out_data_b, out_addr_b, exp_q[0], wa[n]);
        end
        n++;
      end
      adv();
    end
    out_ready = 1'b0;
    in_valid  = 1'b1;
    rand_req(0, 28);
    adv();
    rand_req(0, 28);
    adv();
    in_valid = 1'b0;
    #1;
    checks += 2;
    if (n !== 3) begin errors++; $display("FAIL wrap_count got %0d want 3", n); end
    if (out_valid_b !== 1'b1) begin errors++; $display("FAIL pre_rst_valid got %b want 1", out_valid_b); end
    reset = 1'b1;
    in_valid = 1'b1;
    rand_req(0, 28);
    @(negedge clk);
    #1;
    checks += 3;
    if (out_valid_b !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b want 0", out_valid_b); end
    if (out_addr_b !== BASE_B) begin errors++; $display("FAIL mid_rst_addr got %h want %h", out_addr_b, BASE_B); end
    if (out_addr_a !== BASE_A) begin errors++; $display("FAIL mid_rst_addr_a got %h want %h", out_addr_a, BASE_A); end
    @(negedge clk);
    reset = 1'b0;
    in_valid = 1'b0;
    clear_model();
    #1;
    checks++;
    if (out_valid_b !== 1'b0) begin errors++; $display("FAIL rst_no_accept got %b want 0", out_valid_b); end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_random();
    test_illegal();
    test_wrap_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
